// File: rtl/qrs_event_tx_scheduler.sv
// Buffers R-peak events in a small FIFO and streams each one out as a 10-byte frame
// (SYNC, SEQ, sample[23:0], RR[15:0], TH[15:0], XOR checksum) on a valid/ready byte link.
module qrs_event_tx_scheduler #(
  parameter int         CTR_WIDTH  = 24,
  parameter int         DATA_WIDTH = 11,
  parameter int         FIFO_DEPTH = 4,
  parameter int         GAP_CYCLES = 0,
  parameter logic [7:0] SYNC_BYTE  = 8'hA5
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_peak_valid,
  input  logic [CTR_WIDTH-1:0]        i_r_peak_sample_num,
  input  logic [DATA_WIDTH-1:0]       i_rr_period,
  input  logic [DATA_WIDTH-1:0]       i_qrs_threshold,
  input  logic                        i_en,
  output logic [7:0]                  o_tx_data,
  output logic                        o_tx_valid,
  input  logic                        i_tx_ready,
  output logic [$clog2(FIFO_DEPTH):0] o_fifo_level,
  output logic                        o_overflow,
  input  logic                        i_clr_overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int EW = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic [EW-1:0]   mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [LW-1:0]   count;
  logic [7:0]      seq;
  logic            overflow;
  logic [3:0]      byte_idx;
  logic [GW-1:0]   gap_cnt;
  logic [EW-1:0]   entry_p0;
  logic [EW-1:0]   head_p0;
  logic [79:0]     frame_p1;
  logic            full, empty, pop, push, drop, tx_fire, last_byte, gap_done;

  function automatic logic [7:0] frame_chk(input logic [EW-1:0] e);
    logic [7:0] c;
    c = 8'h00;
    for (int i = 0; i < 8; i++) c = c ^ e[i*8 +: 8];
    return c;
  endfunction

  function automatic logic [79:0] build_frame(input logic [EW-1:0] e);
    return {SYNC_BYTE, e, frame_chk(e)};
  endfunction

  assign full      = (count == LW'(FIFO_DEPTH));
  assign empty     = (count == '0);
  assign head_p0   = mem[rd_ptr];
  assign entry_p0  = {seq, 24'(i_r_peak_sample_num), 16'(i_rr_period), 16'(i_qrs_threshold)};
  assign tx_fire   = (state == SEND) && i_tx_ready;
  assign last_byte = (byte_idx == 4'd9);
  assign gap_done  = (gap_cnt == GW'(GAP_CYCLES - 1));

  // A full FIFO still accepts a strobe when the head is popped on the same edge.
  assign push = i_peak_valid && (!full || pop);
  assign drop = i_peak_valid && full && !pop;

  assign o_fifo_level = count;
  assign o_overflow   = overflow;

  always_comb begin
    state_nxt  = state;
    pop        = 1'b0;
    o_tx_valid = 1'b0;
    o_tx_data  = 8'h00;
    case (state)
      IDLE: begin
        if (i_en && !empty) begin
          pop       = 1'b1;
          state_nxt = SEND;
        end
      end
      SEND: begin
        o_tx_valid = 1'b1;
        o_tx_data  = frame_p1[79:72];
        if (i_tx_ready && last_byte) state_nxt = (GAP_CYCLES > 0) ? GAP : IDLE;
      end
      GAP: begin
        if (gap_done) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state    <= IDLE;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      seq      <= 8'h00;
      overflow <= 1'b0;
      byte_idx <= 4'd0;
      gap_cnt  <= '0;
    end else begin
      state <= state_nxt;
      // Sequence advances on every strobe so the host can detect dropped events.
      if (i_peak_valid) seq <= seq + 8'd1;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + LW'(1);
        2'b01:   count <= count - LW'(1);
        default: count <= count;
      endcase
      if (drop)                overflow <= 1'b1;
      else if (i_clr_overflow) overflow <= 1'b0;
      if (pop)                         byte_idx <= 4'd0;
      else if (tx_fire && !last_byte) byte_idx <= byte_idx + 4'd1;
      if (state == GAP) gap_cnt <= gap_cnt + GW'(1);
      else              gap_cnt <= '0;
    end
  end

  // ---- p0: FIFO write; p1: frame register shifted out one byte per handshake ----
  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr] <= entry_p0;
    if (pop)          frame_p1 <= build_frame(head_p0);
    else if (tx_fire) frame_p1 <= {frame_p1[71:0], 8'h00};
  end

endmodule

// File: tb/tb_qrs_event_tx_scheduler.sv
// Directed bench for qrs_event_tx_scheduler: frame format, latency, backpressure, overflow,
// full-FIFO push/pop, inter-frame gap, enable gating and asynchronous reset.
module tb_qrs_event_tx_scheduler;

  logic        clk = 1'b0;
  logic        rst, peak_valid, en, tx_ready, clr_ovf;
  logic [23:0] sample;
  logic [10:0] rr, th;
  logic [7:0]  d0, d1;
  logic        v0, v1, ovf0, ovf1;
  logic [2:0]  lvl0, lvl1;
  logic        sel;
  logic        mv;
  logic [7:0]  md;
  logic [2:0]  mlvl;
  logic [7:0]  fr [10];
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  assign mv   = sel ? v1 : v0;
  assign md   = sel ? d1 : d0;
  assign mlvl = sel ? lvl1 : lvl0;

  qrs_event_tx_scheduler #(.GAP_CYCLES(0)) dut (
    .i_clk(clk), .i_rst(rst), .i_peak_valid(peak_valid),
    .i_r_peak_sample_num(sample), .i_rr_period(rr), .i_qrs_threshold(th),
    .i_en(en), .o_tx_data(d0), .o_tx_valid(v0), .i_tx_ready(tx_ready),
    .o_fifo_level(lvl0), .o_overflow(ovf0), .i_clr_overflow(clr_ovf)
  );

  qrs_event_tx_scheduler #(.GAP_CYCLES(2)) dut_g (
    .i_clk(clk), .i_rst(rst), .i_peak_valid(peak_valid),
    .i_r_peak_sample_num(sample), .i_rr_period(rr), .i_qrs_threshold(th),
    .i_en(en), .o_tx_data(d1), .o_tx_valid(v1), .i_tx_ready(tx_ready),
    .o_fifo_level(lvl1), .o_overflow(ovf1), .i_clr_overflow(clr_ovf)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [7:0] exp_byte(input logic [7:0] sq, input logic [23:0] s,
                                          input logic [10:0] r, input logic [10:0] t, input int k);
    logic [7:0] b [10];
    b[0] = 8'hA5;
    b[1] = sq;
    b[2] = s[23:16];
    b[3] = s[15:8];
    b[4] = s[7:0];
    b[5] = {5'b0, r[10:8]};
    b[6] = r[7:0];
    b[7] = {5'b0, t[10:8]};
    b[8] = t[7:0];
    b[9] = b[1] ^ b[2] ^ b[3] ^ b[4] ^ b[5] ^ b[6] ^ b[7] ^ b[8];
    return b[k];
  endfunction

  // Called on a falling edge; the event is captured by the following rising edge.
  task automatic strobe(input logic [23:0] s, input logic [10:0] r, input logic [10:0] t);
    peak_valid = 1'b1;
    sample     = s;
    rr         = r;
    th         = t;
    @(negedge clk);
    peak_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    peak_valid = 1'b0;
    en         = 1'b0;
    tx_ready   = 1'b0;
    clr_ovf    = 1'b0;
    sample     = '0;
    rr         = '0;
    th         = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // Waits (bounded) for a frame on the selected DUT and captures all ten bytes with ready high.
  task automatic get_frame(input string tag, input int drop_en_at);
    int n;
    n = 0;
    while (!mv && n < 60) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_start"}, 32'(mv), 32'd1);
    for (int k = 0; k < 10; k++) begin
      fr[k] = md;
      if (k == drop_en_at) en = 1'b0;
      check($sformatf("%s_vld%0d", tag, k), 32'(mv), 32'd1);
      if (k < 9) @(negedge clk);
    end
  endtask

  task automatic check_frame(input string tag, input logic [7:0] sq, input logic [23:0] s,
                             input logic [10:0] r, input logic [10:0] t);
    for (int k = 0; k < 10; k++)
      check($sformatf("%s_b%0d", tag, k), 32'(fr[k]), 32'(exp_byte(sq, s, r, t, k)));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] t1_exp [10];
    int gap;
    t1_exp = '{8'hA5, 8'h00, 8'h01, 8'h23, 8'h45, 8'h01, 8'h2C, 8'h00, 8'h7F, 8'h35};
    sel = 1'b0;

    // Reset state
    do_reset();
    check("rst_vld", 32'(v0), 32'd0);
    check("rst_data", 32'(d0), 32'd0);
    check("rst_lvl", 32'(lvl0), 32'd0);
    check("rst_ovf", 32'(ovf0), 32'd0);
    check("rst_vld_g", 32'(v1), 32'd0);

    // T1: single event, latency N+2, exact frame bytes
    en = 1'b1;
    tx_ready = 1'b1;
    peak_valid = 1'b1;
    sample = 24'h012345;
    rr = 11'd300;
    th = 11'h07F;
    @(negedge clk);
    peak_valid = 1'b0;
    check("t1_vld_n1", 32'(v0), 32'd0);
    check("t1_lvl_n1", 32'(lvl0), 32'd1);
    @(negedge clk);
    check("t1_vld_n2", 32'(v0), 32'd1);
    check("t1_sync_n2", 32'(d0), 32'hA5);
    check("t1_lvl_n2", 32'(lvl0), 32'd0);
    get_frame("t1", -1);
    for (int k = 0; k < 10; k++) check($sformatf("t1_b%0d", k), 32'(fr[k]), 32'(t1_exp[k]));
    @(negedge clk);
    check("t1_idle", 32'(v0), 32'd0);

    // T2: backpressure while byte 3 is presented
    do_reset();
    en = 1'b1;
    tx_ready = 1'b1;
    strobe(24'h012345, 11'd300, 11'h07F);
    gap = 0;
    while (!v0 && gap < 20) begin
      @(negedge clk);
      gap++;
    end
    for (int k = 0; k < 3; k++) begin
      check($sformatf("t2_b%0d", k), 32'(d0), 32'(t1_exp[k]));
      @(negedge clk);
    end
    check("t2_b3", 32'(d0), 32'h23);
    tx_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("t2_hold_d%0d", i), 32'(d0), 32'h23);
      check($sformatf("t2_hold_v%0d", i), 32'(v0), 32'd1);
    end
    tx_ready = 1'b1;
    @(negedge clk);
    for (int k = 4; k < 10; k++) begin
      check($sformatf("t2_b%0d", k), 32'(d0), 32'(t1_exp[k]));
      if (k < 9) @(negedge clk);
    end
    @(negedge clk);
    check("t2_idle", 32'(v0), 32'd0);

    // T3: overflow with scheduler disabled, then drain and observe sequence gap
    do_reset();
    for (int i = 0; i < 6; i++) strobe(24'h000100 + 24'(i), 11'(i + 1), 11'(i + 2));
    check("t3_lvl", 32'(lvl0), 32'd4);
    check("t3_ovf", 32'(ovf0), 32'd1);
    check("t3_vld", 32'(v0), 32'd0);
    en = 1'b1;
    tx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      get_frame($sformatf("t3_f%0d", i), -1);
      check_frame($sformatf("t3_f%0d", i), 8'(i), 24'h000100 + 24'(i), 11'(i + 1), 11'(i + 2));
      @(negedge clk);
    end
    check("t3_lvl_drained", 32'(lvl0), 32'd0);
    check("t3_ovf_sticky", 32'(ovf0), 32'd1);
    clr_ovf = 1'b1;
    @(negedge clk);
    clr_ovf = 1'b0;
    check("t3_ovf_clr", 32'(ovf0), 32'd0);
    strobe(24'hABCDEF, 11'h5A5, 11'h3C3);
    get_frame("t3_f6", -1);
    check_frame("t3_f6", 8'h06, 24'hABCDEF, 11'h5A5, 11'h3C3);
    @(negedge clk);

    // T4: full FIFO, strobe on the same edge as the IDLE pop
    do_reset();
    tx_ready = 1'b1;
    for (int i = 0; i < 4; i++) strobe(24'h020000 + 24'(i), 11'(10 + i), 11'(20 + i));
    check("t4_lvl_full", 32'(lvl0), 32'd4);
    en = 1'b1;
    peak_valid = 1'b1;
    sample = 24'h020004;
    rr = 11'd14;
    th = 11'd24;
    @(negedge clk);
    peak_valid = 1'b0;
    check("t4_lvl_same", 32'(lvl0), 32'd4);
    check("t4_ovf", 32'(ovf0), 32'd0);
    check("t4_vld", 32'(v0), 32'd1);
    for (int i = 0; i < 5; i++) begin
      get_frame($sformatf("t4_f%0d", i), -1);
      check_frame($sformatf("t4_f%0d", i), 8'(i), 24'h020000 + 24'(i), 11'(10 + i), 11'(20 + i));
      @(negedge clk);
    end

    // T5: inter-frame gap with GAP_CYCLES=2, and enable dropped mid-frame
    do_reset();
    sel = 1'b1;
    tx_ready = 1'b1;
    strobe(24'h030000, 11'd100, 11'd200);
    strobe(24'h030001, 11'd101, 11'd201);
    en = 1'b1;
    get_frame("t5_a", -1);
    check_frame("t5_a", 8'h00, 24'h030000, 11'd100, 11'd200);
    gap = 0;
    do begin
      @(negedge clk);
      if (!mv) gap++;
    end while (!mv && gap < 20);
    check("t5_gap", 32'(gap), 32'd3);
    get_frame("t5_b", -1);
    check_frame("t5_b", 8'h01, 24'h030001, 11'd101, 11'd201);
    @(negedge clk);
    strobe(24'h030002, 11'd102, 11'd202);
    strobe(24'h030003, 11'd103, 11'd203);
    get_frame("t5_c", 4);
    check_frame("t5_c", 8'h02, 24'h030002, 11'd102, 11'd202);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check($sformatf("t5_hold%0d", i), 32'(mv), 32'd0);
    end
    check("t5_lvl_hold", 32'(mlvl), 32'd1);
    en = 1'b1;
    get_frame("t5_d", -1);
    check_frame("t5_d", 8'h03, 24'h030003, 11'd103, 11'd203);
    @(negedge clk);

    // T6: asynchronous reset mid-frame with events queued
    do_reset();
    sel = 1'b0;
    tx_ready = 1'b1;
    strobe(24'h040000, 11'h1AB, 11'd50);
    strobe(24'h040001, 11'd51, 11'd52);
    strobe(24'h040002, 11'd53, 11'd54);
    en = 1'b1;
    gap = 0;
    while (!v0 && gap < 20) begin
      @(negedge clk);
      gap++;
    end
    repeat (5) @(negedge clk);
    check("t6_b5", 32'(d0), 32'h01);
    rst = 1'b1;
    #1;
    check("t6_vld_async", 32'(v0), 32'd0);
    check("t6_lvl_async", 32'(lvl0), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("t6_vld_after", 32'(v0), 32'd0);
    check("t6_lvl_after", 32'(lvl0), 32'd0);
    check("t6_ovf_after", 32'(ovf0), 32'd0);
    strobe(24'h050505, 11'd77, 11'd88);
    get_frame("t6_f", -1);
    check_frame("t6_f", 8'h00, 24'h050505, 11'd77, 11'd88);
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
